// File: rtl/stepper_controller.sv
// Sequencing FSM for the stepper-motor ASIP datapath: fetch/execute, delay-paced pauses and moves.
// Optional half-step moves (movrhs) are built only when MOVRHS_EN is defined.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// RESET      | idle after reset, all controls low
// FETCH      | instruction ROM registers the pc address
// EXEC       | decode the opcode flags and drive the datapath for one cycle
// PAUSE_WAIT | delay counter running for a pause
// MOVE_CHECK | test the remaining signed step count in temp
// STEP       | one position update, temp moved one count toward zero
// STEP2      | second position update of a half-step move (MOVRHS_EN only)
// STEP_WAIT  | delay counter running between steps
// ABS_WAIT   | delay counter running after an absolute move
module stepper_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       br,
  input  logic       brz,
  input  logic       addi,
  input  logic       subi,
  input  logic       sr0,
  input  logic       srh0,
  input  logic       clr,
  input  logic       mov,
  input  logic       mova,
  input  logic       movr,
  input  logic       movrhs,
  input  logic       pause,
  input  logic       delay_done,
  input  logic       temp_is_positive,
  input  logic       temp_is_negative,
  input  logic       temp_is_zero,
  input  logic       register0_is_zero,
  output logic       write_reg_file,
  output logic       result_mux_select,
  output logic [1:0] op1_mux_select,
  output logic [1:0] op2_mux_select,
  output logic       start_delay_counter,
  output logic       enable_delay_counter,
  output logic       commit_branch,
  output logic       increment_pc,
  output logic       alu_add_sub,
  output logic       alu_set_low,
  output logic       alu_set_high,
  output logic       load_temp,
  output logic       increment_temp,
  output logic       decrement_temp,
  output logic [1:0] select_immediate,
  output logic [1:0] select_write_address,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RESET      = 4'd0,
    S_FETCH      = 4'd1,
    S_EXEC       = 4'd2,
    S_PAUSE_WAIT = 4'd3,
    S_MOVE_CHECK = 4'd4,
    S_STEP       = 4'd5,
    S_STEP2      = 4'd6,
    S_STEP_WAIT  = 4'd7,
    S_ABS_WAIT   = 4'd8
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP, OP_BR, OP_BRZ, OP_PAUSE, OP_MOVA, OP_MOVR, OP_MOVRHS,
    OP_ADDI, OP_SUBI, OP_SR0, OP_SRH0, OP_CLR, OP_MOV
  } op_t;

  state_t cur;
  op_t    op;

`ifdef MOVRHS_EN
  logic half_step;
  logic step_neg;
`endif

  assign state             = cur;
  assign result_mux_select = 1'b0;

  // Priority encode the decoded-instruction flags; several may be set at once.
  always_comb begin
    op = OP_NOP;
    if (br)            op = OP_BR;
    else if (brz)      op = OP_BRZ;
    else if (pause)    op = OP_PAUSE;
    else if (mova)     op = OP_MOVA;
    else if (movr)     op = OP_MOVR;
    else if (movrhs) begin
`ifdef MOVRHS_EN
      op = OP_MOVRHS;
`else
      op = OP_NOP;
`endif
    end
    else if (addi)     op = OP_ADDI;
    else if (subi)     op = OP_SUBI;
    else if (sr0)      op = OP_SR0;
    else if (srh0)     op = OP_SRH0;
    else if (clr)      op = OP_CLR;
    else if (mov)      op = OP_MOV;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= S_RESET;
`ifdef MOVRHS_EN
      half_step <= 1'b0;
      step_neg  <= 1'b0;
`endif
    end else begin
      case (cur)
        S_RESET: cur <= S_FETCH;
        S_FETCH: cur <= S_EXEC;
        S_EXEC: begin
          case (op)
            OP_PAUSE: cur <= S_PAUSE_WAIT;
            OP_MOVA:  cur <= S_ABS_WAIT;
            OP_MOVR: begin
              cur <= S_MOVE_CHECK;
`ifdef MOVRHS_EN
              half_step <= 1'b0;
`endif
            end
`ifdef MOVRHS_EN
            OP_MOVRHS: begin
              cur       <= S_MOVE_CHECK;
              half_step <= 1'b1;
            end
`endif
            default:  cur <= S_FETCH;
          endcase
        end
        S_PAUSE_WAIT, S_ABS_WAIT: if (delay_done) cur <= S_FETCH;
        S_MOVE_CHECK: cur <= temp_is_zero ? S_FETCH : S_STEP;
        S_STEP: begin
`ifdef MOVRHS_EN
          // temp may reach zero in this cycle, so STEP2 reuses the direction seen here
          step_neg <= temp_is_negative;
          cur      <= half_step ? S_STEP2 : S_STEP_WAIT;
`else
          cur <= S_STEP_WAIT;
`endif
        end
`ifdef MOVRHS_EN
        S_STEP2: cur <= S_STEP_WAIT;
`endif
        S_STEP_WAIT: if (delay_done) cur <= S_MOVE_CHECK;
        default: cur <= S_RESET;
      endcase
    end
  end

  always_comb begin
    write_reg_file       = 1'b0;
    op1_mux_select       = 2'd0;
    op2_mux_select       = 2'd0;
    start_delay_counter  = 1'b0;
    enable_delay_counter = 1'b0;
    commit_branch        = 1'b0;
    increment_pc         = 1'b0;
    alu_add_sub          = 1'b0;
    alu_set_low          = 1'b0;
    alu_set_high         = 1'b0;
    load_temp            = 1'b0;
    increment_temp       = 1'b0;
    decrement_temp       = 1'b0;
    select_immediate     = 2'd0;
    select_write_address = 2'd0;
    case (cur)
      S_EXEC: begin
        case (op)
          OP_BR: begin
            op2_mux_select = 2'd1;
            commit_branch  = 1'b1;
          end
          OP_BRZ: begin
            if (register0_is_zero) begin
              op2_mux_select = 2'd1;
              commit_branch  = 1'b1;
            end else begin
              increment_pc = 1'b1;
            end
          end
          OP_PAUSE: start_delay_counter = 1'b1;
          OP_MOVA: begin
            op1_mux_select       = 2'd1;
            op2_mux_select       = 2'd1;
            write_reg_file       = 1'b1;
            select_write_address = 2'd2;
            start_delay_counter  = 1'b1;
          end
          OP_MOVR, OP_MOVRHS: load_temp = 1'b1;
          OP_ADDI, OP_SUBI: begin
            op1_mux_select   = 2'd1;
            op2_mux_select   = 2'd1;
            select_immediate = 2'd1;
            alu_add_sub      = (op == OP_SUBI);
            write_reg_file   = 1'b1;
            increment_pc     = 1'b1;
          end
          OP_SR0, OP_SRH0: begin
            op1_mux_select       = 2'd2;
            op2_mux_select       = 2'd1;
            select_immediate     = 2'd2;
            alu_set_low          = (op == OP_SR0);
            alu_set_high         = (op == OP_SRH0);
            write_reg_file       = 1'b1;
            select_write_address = 2'd3;
            increment_pc         = 1'b1;
          end
          OP_CLR: begin
            op2_mux_select   = 2'd1;
            select_immediate = 2'd3;
            alu_set_low      = 1'b1;
            alu_set_high     = 1'b1;
            write_reg_file   = 1'b1;
            increment_pc     = 1'b1;
          end
          OP_MOV: begin
            op1_mux_select = 2'd1;
            alu_set_low    = 1'b1;
            alu_set_high   = 1'b1;
            write_reg_file = 1'b1;
            increment_pc   = 1'b1;
          end
          default: increment_pc = 1'b1;
        endcase
      end
      S_PAUSE_WAIT, S_ABS_WAIT: begin
        enable_delay_counter = 1'b1;
        increment_pc         = delay_done;
      end
      S_MOVE_CHECK: increment_pc = temp_is_zero;
      S_STEP: begin
        op1_mux_select       = 2'd3;
        op2_mux_select       = 2'd1;
        select_immediate     = 2'd3;
        alu_add_sub          = temp_is_negative;
        write_reg_file       = 1'b1;
        select_write_address = 2'd2;
        decrement_temp       = temp_is_positive;
        increment_temp       = temp_is_negative;
`ifdef MOVRHS_EN
        start_delay_counter  = ~half_step;
`else
        start_delay_counter  = 1'b1;
`endif
      end
`ifdef MOVRHS_EN
      S_STEP2: begin
        op1_mux_select       = 2'd3;
        op2_mux_select       = 2'd1;
        select_immediate     = 2'd3;
        alu_add_sub          = step_neg;
        write_reg_file       = 1'b1;
        select_write_address = 2'd2;
        start_delay_counter  = 1'b1;
      end
`endif
      S_STEP_WAIT: enable_delay_counter = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stepper_controller.sv
// Directed bench for stepper_controller with a small datapath plant (pc, position, temp, delay counter).
// Expected output vectors and plant values are queued at drive time and popped at the sample point.
module tb_stepper_controller;

  logic clk = 1'b0;
  logic reset;
  logic [11:0] ops;
  logic r0z;
  logic br, brz, addi, subi, sr0, srh0, clr, mov, mova, movr, movrhs, pause;
  logic delay_done, temp_is_positive, temp_is_negative, temp_is_zero;
  logic write_reg_file, result_mux_select;
  logic [1:0] op1_mux_select, op2_mux_select;
  logic start_delay_counter, enable_delay_counter, commit_branch, increment_pc;
  logic alu_add_sub, alu_set_low, alu_set_high;
  logic load_temp, increment_temp, decrement_temp;
  logic [1:0] select_immediate, select_write_address;
  logic [3:0] state;

  localparam logic [11:0] K_BR = 12'h800, K_BRZ = 12'h400, K_PAUSE = 12'h200, K_MOVA = 12'h100;
  localparam logic [11:0] K_MOVR = 12'h080, K_MOVRHS = 12'h040, K_ADDI = 12'h020, K_SUBI = 12'h010;
  localparam logic [11:0] K_SR0 = 12'h008, K_SRH0 = 12'h004, K_CLR = 12'h002, K_MOV = 12'h001;

  assign {br, brz, pause, mova, movr, movrhs, addi, subi, sr0, srh0, clr, mov} = ops;

  // datapath plant
  logic [7:0] pc, position, temp, dcnt;
  logic pc_ld, pos_ld;
  logic [7:0] pc_ld_val, pos_ld_val, temp_ld_val, br_off, delay_len;

  always @(posedge clk) begin
    if (reset) dcnt <= 8'd0;
    else if (start_delay_counter) dcnt <= delay_len;
    else if (enable_delay_counter && dcnt != 8'd0) dcnt <= dcnt - 8'd1;
    if (pc_ld) pc <= pc_ld_val;
    else if (commit_branch) pc <= pc + br_off;
    else if (increment_pc) pc <= pc + 8'd1;
    if (pos_ld) position <= pos_ld_val;
    else if (write_reg_file && select_write_address == 2'd2 && op1_mux_select == 2'd3)
      position <= alu_add_sub ? position - 8'd1 : position + 8'd1;
    if (load_temp) temp <= temp_ld_val;
    else if (increment_temp) temp <= temp + 8'd1;
    else if (decrement_temp) temp <= temp - 8'd1;
  end

  assign delay_done       = (dcnt == 8'd1);
  assign temp_is_zero     = (temp == 8'd0);
  assign temp_is_negative = temp[7];
  assign temp_is_positive = !temp[7] && (temp != 8'd0);

  stepper_controller dut (
    .clk(clk), .reset(reset),
    .br(br), .brz(brz), .addi(addi), .subi(subi), .sr0(sr0), .srh0(srh0), .clr(clr), .mov(mov),
    .mova(mova), .movr(movr), .movrhs(movrhs), .pause(pause),
    .delay_done(delay_done), .temp_is_positive(temp_is_positive),
    .temp_is_negative(temp_is_negative), .temp_is_zero(temp_is_zero),
    .register0_is_zero(r0z),
    .write_reg_file(write_reg_file), .result_mux_select(result_mux_select),
    .op1_mux_select(op1_mux_select), .op2_mux_select(op2_mux_select),
    .start_delay_counter(start_delay_counter), .enable_delay_counter(enable_delay_counter),
    .commit_branch(commit_branch), .increment_pc(increment_pc),
    .alu_add_sub(alu_add_sub), .alu_set_low(alu_set_low), .alu_set_high(alu_set_high),
    .load_temp(load_temp), .increment_temp(increment_temp), .decrement_temp(decrement_temp),
    .select_immediate(select_immediate), .select_write_address(select_write_address),
    .state(state)
  );

  always #5 clk = ~clk;

  string       tag_q[$];
  logic [31:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic push(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    string t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%0h required=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return {8'h00, write_reg_file, result_mux_select, op1_mux_select, op2_mux_select,
            start_delay_counter, enable_delay_counter, commit_branch, increment_pc,
            alu_add_sub, alu_set_low, alu_set_high, load_temp, increment_temp, decrement_temp,
            select_immediate, select_write_address, state};
  endfunction

  function automatic logic [31:0] ev(input logic [3:0] st, input logic wr,
                                     input logic [1:0] o1, input logic [1:0] o2,
                                     input logic sd, input logic ed, input logic cb, input logic ip,
                                     input logic as, input logic sl, input logic sh,
                                     input logic lt, input logic it, input logic dt,
                                     input logic [1:0] si, input logic [1:0] wa);
    return {8'h00, wr, 1'b0, o1, o2, sd, ed, cb, ip, as, sl, sh, lt, it, dt, si, wa, st};
  endfunction

  // Hold reset for one cycle while the plant loads pc/position; returns at a FETCH sample point.
  task automatic preload(input logic [7:0] pcv, input logic [7:0] posv);
    reset = 1'b1; ops = 12'h000;
    pc_ld = 1'b1; pc_ld_val = pcv;
    pos_ld = 1'b1; pos_ld_val = posv;
    @(negedge clk);
    reset = 1'b0; pc_ld = 1'b0; pos_ld = 1'b0;
    @(negedge clk);
  endtask

  // Called at a FETCH sample point; the EXEC vector must already be queued.
  task automatic run_op(input logic [11:0] op, output int cyc, output int en_n,
                        output int ip_n, output logic [7:0] pos_first);
    int guard;
    bit seen_wait;
    ops = op; cyc = 1; en_n = 0; ip_n = 0; pos_first = 8'hAA; seen_wait = 0;
    @(negedge clk);
    cyc++;
    pop_chk(obs_vec());
    en_n += int'(enable_delay_counter);
    ip_n += int'(increment_pc);
    guard = 0;
    while (guard < 300) begin
      @(negedge clk);
      guard++;
      if (state == 4'd1) break;
      cyc++;
      en_n += int'(enable_delay_counter);
      ip_n += int'(increment_pc);
      if (state == 4'd7 && !seen_wait) begin
        seen_wait = 1;
        pos_first = position;
      end
    end
    if (state != 4'd1) begin
      errors++; checks++;
      $display("FAIL timeout_return_to_fetch state=%0d required=1", state);
    end
    ops = 12'h000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, en_n, ip_n, g;
    logic [7:0] pf;
    reset = 1'b1; ops = 12'h000; r0z = 1'b0;
    pc_ld = 1'b1; pc_ld_val = 8'd0; pos_ld = 1'b1; pos_ld_val = 8'd0;
    temp_ld_val = 8'd0; br_off = 8'd0; delay_len = 8'd1;

    push("reset_outputs", ev(4'd0,0,2'd0,2'd0,0,0,0,0,0,0,0,0,0,0,2'd0,2'd0));
    @(negedge clk);
    pop_chk(obs_vec());
    reset = 1'b0; pc_ld = 1'b0; pos_ld = 1'b0;
    push("fetch_outputs", ev(4'd1,0,2'd0,2'd0,0,0,0,0,0,0,0,0,0,0,2'd0,2'd0));
    @(negedge clk);
    pop_chk(obs_vec());

    push("addi_exec", ev(4'd2,1,2'd1,2'd1,0,0,0,1,0,0,0,0,0,0,2'd1,2'd0));
    push("addi_cycles", 32'd2);
    push("addi_pc", 32'd1);
    run_op(K_ADDI, cyc, en_n, ip_n, pf);
    pop_chk(cyc); pop_chk({24'h0, pc});

    preload(8'd10, 8'd0); r0z = 1'b1; br_off = 8'hFE;
    push("brz_taken_exec", ev(4'd2,0,2'd0,2'd1,0,0,1,0,0,0,0,0,0,0,2'd0,2'd0));
    push("brz_taken_cycles", 32'd2);
    push("brz_taken_pc", 32'd8);
    run_op(K_BRZ, cyc, en_n, ip_n, pf);
    pop_chk(cyc); pop_chk({24'h0, pc});

    preload(8'd10, 8'd0); r0z = 1'b0;
    push("brz_not_taken_exec", ev(4'd2,0,2'd0,2'd0,0,0,0,1,0,0,0,0,0,0,2'd0,2'd0));
    push("brz_not_taken_pc", 32'd11);
    run_op(K_BRZ, cyc, en_n, ip_n, pf);
    pop_chk({24'h0, pc});

    preload(8'd20, 8'd0); br_off = 8'd5;
    push("br_over_addi_exec", ev(4'd2,0,2'd0,2'd1,0,0,1,0,0,0,0,0,0,0,2'd0,2'd0));
    push("br_pc", 32'd25);
    run_op(K_BR | K_ADDI, cyc, en_n, ip_n, pf);
    pop_chk({24'h0, pc});

    push("subi_exec", ev(4'd2,1,2'd1,2'd1,0,0,0,1,1,0,0,0,0,0,2'd1,2'd0));
    run_op(K_SUBI, cyc, en_n, ip_n, pf);
    push("sr0_exec", ev(4'd2,1,2'd2,2'd1,0,0,0,1,0,1,0,0,0,0,2'd2,2'd3));
    run_op(K_SR0, cyc, en_n, ip_n, pf);
    push("srh0_exec", ev(4'd2,1,2'd2,2'd1,0,0,0,1,0,0,1,0,0,0,2'd2,2'd3));
    run_op(K_SRH0, cyc, en_n, ip_n, pf);
    push("clr_exec", ev(4'd2,1,2'd0,2'd1,0,0,0,1,0,1,1,0,0,0,2'd3,2'd0));
    run_op(K_CLR, cyc, en_n, ip_n, pf);
    push("mov_exec", ev(4'd2,1,2'd1,2'd0,0,0,0,1,0,1,1,0,0,0,2'd0,2'd0));
    run_op(K_MOV, cyc, en_n, ip_n, pf);
    push("nop_exec", ev(4'd2,0,2'd0,2'd0,0,0,0,1,0,0,0,0,0,0,2'd0,2'd0));
    push("nop_cycles", 32'd2);
    run_op(12'h000, cyc, en_n, ip_n, pf);
    pop_chk(cyc);

    delay_len = 8'd5;
    push("pause_exec", ev(4'd2,0,2'd0,2'd0,1,0,0,0,0,0,0,0,0,0,2'd0,2'd0));
    push("pause_cycles", 32'd7);
    push("pause_enable_count", 32'd5);
    push("pause_inc_pc_count", 32'd1);
    run_op(K_PAUSE, cyc, en_n, ip_n, pf);
    pop_chk(cyc); pop_chk(en_n); pop_chk(ip_n);

    delay_len = 8'd3;
    push("mova_exec", ev(4'd2,1,2'd1,2'd1,1,0,0,0,0,0,0,0,0,0,2'd0,2'd2));
    push("mova_cycles", 32'd5);
    push("mova_enable_count", 32'd3);
    run_op(K_MOVA, cyc, en_n, ip_n, pf);
    pop_chk(cyc); pop_chk(en_n);

    preload(8'd0, 8'd1); temp_ld_val = 8'hFE; delay_len = 8'd4;
    push("movr_exec", ev(4'd2,0,2'd0,2'd0,0,0,0,0,0,0,0,1,0,0,2'd0,2'd0));
    push("movr_neg_cycles", 32'd15);
    push("movr_neg_first_pos", 32'd0);
    push("movr_neg_final_pos", 32'd255);
    push("movr_neg_temp", 32'd0);
    push("movr_neg_inc_pc_count", 32'd1);
    run_op(K_MOVR, cyc, en_n, ip_n, pf);
    pop_chk(cyc); pop_chk({24'h0, pf}); pop_chk({24'h0, position});
    pop_chk({24'h0, temp}); pop_chk(ip_n);

    temp_ld_val = 8'd0;
    push("movr_zero_exec", ev(4'd2,0,2'd0,2'd0,0,0,0,0,0,0,0,1,0,0,2'd0,2'd0));
    push("movr_zero_cycles", 32'd3);
    push("movr_zero_pos", 32'd255);
    run_op(K_MOVR, cyc, en_n, ip_n, pf);
    pop_chk(cyc); pop_chk({24'h0, position});

    temp_ld_val = 8'd1; delay_len = 8'd2;
    push("movr_wrap_exec", ev(4'd2,0,2'd0,2'd0,0,0,0,0,0,0,0,1,0,0,2'd0,2'd0));
    push("movr_wrap_cycles", 32'd7);
    push("movr_wrap_pos", 32'd0);
    run_op(K_MOVR, cyc, en_n, ip_n, pf);
    pop_chk(cyc); pop_chk({24'h0, position});

    preload(8'd30, 8'd6); temp_ld_val = 8'd1; delay_len = 8'd2;
`ifdef MOVRHS_EN
    push("movrhs_exec", ev(4'd2,0,2'd0,2'd0,0,0,0,0,0,0,0,1,0,0,2'd0,2'd0));
    push("movrhs_cycles", 32'd8);
    push("movrhs_pos", 32'd8);
    push("movrhs_pc", 32'd31);
`else
    push("movrhs_nop_exec", ev(4'd2,0,2'd0,2'd0,0,0,0,1,0,0,0,0,0,0,2'd0,2'd0));
    push("movrhs_nop_cycles", 32'd2);
    push("movrhs_nop_pos", 32'd6);
    push("movrhs_nop_pc", 32'd31);
`endif
    run_op(K_MOVRHS, cyc, en_n, ip_n, pf);
    pop_chk(cyc); pop_chk({24'h0, position}); pop_chk({24'h0, pc});

    // reset in the middle of a move
    preload(8'd0, 8'd10); temp_ld_val = 8'd3; delay_len = 8'd20;
    ops = K_MOVR;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (state != 4'd5 && g < 50);
    push("step_outputs", ev(4'd5,1,2'd3,2'd1,1,0,0,0,0,0,0,0,0,1,2'd3,2'd2));
    pop_chk(obs_vec());
    @(negedge clk);
    push("step_wait_outputs", ev(4'd7,0,2'd0,2'd0,0,1,0,0,0,0,0,0,0,0,2'd0,2'd0));
    push("step_pos", 32'd11);
    pop_chk(obs_vec());
    pop_chk({24'h0, position});
    reset = 1'b1; ops = 12'h000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      push("mid_move_reset", ev(4'd0,0,2'd0,2'd0,0,0,0,0,0,0,0,0,0,0,2'd0,2'd0));
      pop_chk(obs_vec());
    end
    reset = 1'b0;
    @(negedge clk);
    push("fetch_after_reset", ev(4'd1,0,2'd0,2'd0,0,0,0,0,0,0,0,0,0,0,2'd0,2'd0));
    pop_chk(obs_vec());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
